// File: rtl/param_sweep_ctrl.sv
// param_sweep_ctrl
// Steps through every combination of three buses {c,b,a} as an odometer
// (a is the least-significant digit, c the most). Each combination is offered
// to a sink with a valid/ready handshake; after it is accepted, the offer is
// held off for HOLD idle cycles. A start/done pair frames each sweep, and
// abort drops a running sweep without a done pulse.
//
// Handshake: valid is high in exactly the cycles the FSM is in DRIVE. A
// combination is transferred on a rising edge where valid=1, ready=1 and
// abort=0. While valid=1 and the transfer has not happened, valid stays high
// and {c,b,a} stay stable.

module param_sweep_ctrl #(
    parameter int unsigned SIZE1 = 1,
    parameter int unsigned SIZE2 = 6,
    parameter int unsigned FOO   = 3,
    parameter int unsigned HOLD  = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     ready,
    output logic [SIZE1-1:0]         a,
    output logic [SIZE2-1:0]         b,
    output logic [FOO-1:0]           c,
    output logic                     valid,
    output logic                     busy,
    output logic                     done,
    output logic [SIZE1+SIZE2+FOO:0] step_cnt,
    output logic [1:0]               state_dbg
);

    // Total width of one combination; a full sweep is 2**W accepted steps.
    localparam int unsigned W = SIZE1 + SIZE2 + FOO;

    // Hold counter preload: counts HOLD-1 down to 0, giving HOLD idle cycles.
    // The HOLD=0 case never enters the hold state, so its preload is unused.
    localparam logic [3:0] HOLD_LOAD = (HOLD == 0) ? 4'd0 : 4'(HOLD - 1);
    localparam logic       HOLD_NONE = (HOLD == 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [SIZE1-1:0] a_q, a_d;
    logic [SIZE2-1:0] b_q, b_d;
    logic [FOO-1:0]   c_q, c_d;
    logic [3:0]       hold_q, hold_d;
    logic [W:0]       step_q, step_d;

    // Odometer successor of the current combination and the last-step flag.
    logic [SIZE1-1:0] a_inc;
    logic [SIZE2-1:0] b_inc;
    logic [FOO-1:0]   c_inc;
    logic             a_wrap;
    logic             b_wrap;
    logic             last_combo;
    logic             accept;

    // Per-digit increment with carry: b moves on an a wrap, c on a joint a/b wrap.
    always_comb begin
        a_wrap     = &a_q;
        b_wrap     = &b_q;
        a_inc      = a_q + SIZE1'(1);
        b_inc      = a_wrap ? (b_q + SIZE2'(1)) : b_q;
        c_inc      = (a_wrap && b_wrap) ? (c_q + FOO'(1)) : c_q;
        last_combo = a_wrap && b_wrap && (&c_q);
    end

    // A step is taken only when offered, accepted, and not overridden by abort.
    always_comb begin
        accept = (state_q == ST_DRIVE) && ready && !abort;
    end

    // Sweep sequencing: next state, odometer, hold counter and step count.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        hold_d  = hold_q;
        step_d  = step_q;

        case (state_q)
            ST_IDLE: begin
                // Last sweep's values stay visible until the next start.
                if (start) begin
                    state_d = ST_DRIVE;
                    a_d     = '0;
                    b_d     = '0;
                    c_d     = '0;
                    step_d  = '0;
                end
            end

            ST_DRIVE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    step_d = step_q + (W + 1)'(1);
                    if (last_combo) begin
                        state_d = ST_FIN;
                    end else if (HOLD_NONE) begin
                        // Back-to-back offers: advance and keep valid high.
                        a_d = a_inc;
                        b_d = b_inc;
                        c_d = c_inc;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
            end

            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hold_q == 4'd0) begin
                    // The accepted value is held through the idle gap and
                    // only advances as the next offer begins.
                    state_d = ST_DRIVE;
                    a_d     = a_inc;
                    b_d     = b_inc;
                    c_d     = c_inc;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end

            ST_FIN: begin
                // One-cycle completion marker; combination stays all-ones.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            hold_q  <= 4'd0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
        end
    end

    // Outputs are decoded straight from registered state.
    always_comb begin
        a         = a_q;
        b         = b_q;
        c         = c_q;
        valid     = (state_q == ST_DRIVE);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FIN);
        step_cnt  = step_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_param_sweep_ctrl.sv
// Bench for param_sweep_ctrl. Two instances share the clock and reset:
//   d: SIZE1=1 SIZE2=6 FOO=3 HOLD=3 (1024 steps, 3 idle cycles per step)
//   s: SIZE1=1 SIZE2=2 FOO=1 HOLD=0 (16 steps, back-to-back offers)
// The reference model tracks each sweep as "next value / time it is offered /
// accepted count" and derives the expected outputs for every cycle from that.

module tb_param_sweep_ctrl;

  localparam int D_HOLD = 3;
  localparam int D_MAX  = (1 << 10) - 1;
  localparam int S_HOLD = 0;
  localparam int S_MAX  = (1 << 4) - 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start_d, abort_d, ready_d;
  logic [0:0]  d_a;
  logic [5:0]  d_b;
  logic [2:0]  d_c;
  logic        d_valid, d_busy, d_done;
  logic [10:0] d_step;
  logic [1:0]  d_state;
  logic [31:0] d_abc;

  logic        start_s, abort_s, ready_s;
  logic [0:0]  s_a;
  logic [1:0]  s_b;
  logic [0:0]  s_c;
  logic        s_valid, s_busy, s_done;
  logic [4:0]  s_step;
  logic [1:0]  s_state;
  logic [31:0] s_abc;

  assign d_abc = 32'({d_c, d_b, d_a});
  assign s_abc = 32'({s_c, s_b, s_a});

  param_sweep_ctrl #(.SIZE1(1), .SIZE2(6), .FOO(3), .HOLD(D_HOLD)) dut_d (
    .clock(clk), .reset_n(rst_n), .start(start_d), .abort(abort_d), .ready(ready_d),
    .a(d_a), .b(d_b), .c(d_c), .valid(d_valid), .busy(d_busy), .done(d_done),
    .step_cnt(d_step), .state_dbg(d_state)
  );

  param_sweep_ctrl #(.SIZE1(1), .SIZE2(2), .FOO(1), .HOLD(S_HOLD)) dut_s (
    .clock(clk), .reset_n(rst_n), .start(start_s), .abort(abort_s), .ready(ready_s),
    .a(s_a), .b(s_b), .c(s_c), .valid(s_valid), .busy(s_busy), .done(s_done),
    .step_cnt(s_step), .state_dbg(s_state)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_active   [2];
  int m_next     [2];
  int m_prev     [2];
  int m_frozen   [2];
  int m_cnt      [2];
  int m_offer    [2];
  int m_done_cyc [2];
  int m_cyc      [2];
  int m_hold     [2];
  int m_max      [2];
  int n_done     [2];

  // Compare this cycle's outputs with the model, then advance the model with
  // the inputs that the next rising edge will sample.
  task automatic mon(input int i, input logic rst, input logic st, input logic ab,
                     input logic rd, input logic vld, input logic bsy, input logic dn,
                     input logic [31:0] abc, input logic [31:0] step);
    string pfx;
    bit    e_valid;
    bit    e_done;
    bit    e_busy;
    int    e_abc;
    pfx = (i == 0) ? "d" : "s";
    if (!rst) begin
      m_active[i]   = 1'b0;
      m_frozen[i]   = 0;
      m_cnt[i]      = 0;
      m_done_cyc[i] = -1;
    end
    e_valid = m_active[i] && (m_cyc[i] >= m_offer[i]);
    e_abc   = m_active[i] ? (e_valid ? m_next[i] : m_prev[i]) : m_frozen[i];
    e_done  = (m_cyc[i] == m_done_cyc[i]);
    e_busy  = m_active[i] || e_done;

    chk({pfx, ".valid"}, 32'(vld), 32'(e_valid));
    chk({pfx, ".busy"},  32'(bsy), 32'(e_busy));
    chk({pfx, ".done"},  32'(dn),  32'(e_done));
    chk({pfx, ".abc"},   abc,      32'(e_abc));
    chk({pfx, ".step"},  step,     32'(m_cnt[i]));
    if (dn) n_done[i]++;

    if (rst) begin
      if (e_done) begin
        // completion cycle: start and abort have no effect
      end else if (!m_active[i]) begin
        if (st) begin
          m_active[i] = 1'b1;
          m_cnt[i]    = 0;
          m_next[i]   = 0;
          m_prev[i]   = 0;
          m_offer[i]  = m_cyc[i] + 1;
        end
      end else if (ab) begin
        m_active[i] = 1'b0;
        m_frozen[i] = e_abc;
      end else if (e_valid && rd) begin
        m_cnt[i]++;
        if (m_next[i] == m_max[i]) begin
          m_active[i]   = 1'b0;
          m_frozen[i]   = m_max[i];
          m_done_cyc[i] = m_cyc[i] + 1;
        end else begin
          m_prev[i]  = m_next[i];
          m_next[i]  = m_next[i] + 1;
          m_offer[i] = m_cyc[i] + m_hold[i] + 1;
        end
      end
    end
    m_cyc[i]++;
  endtask

  always @(negedge clk) begin
    mon(0, rst_n, start_d, abort_d, ready_d, d_valid, d_busy, d_done, d_abc, 32'(d_step));
    mon(1, rst_n, start_s, abort_s, ready_s, s_valid, s_busy, s_done, s_abc, 32'(s_step));
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int seen;
    int nv;
    int found;
    int bp_cnt;
    int wrap_pending;
    int done_before;
    int fin;

    m_hold[0] = D_HOLD;
    m_hold[1] = S_HOLD;
    m_max[0]  = D_MAX;
    m_max[1]  = S_MAX;
    start_d = 1'b0; abort_d = 1'b0; ready_d = 1'b0;
    start_s = 1'b0; abort_s = 1'b0; ready_s = 1'b0;

    repeat (3) tick();
    chk("rst_d_busy", 32'(d_busy), 0);
    chk("rst_d_abc", d_abc, 0);
    rst_n = 1'b1;
    tick();

    // Full sweep on the small instance with ready tied high.
    ready_s = 1'b1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    seen = 0;
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      if (s_done) begin
        seen = 1;
        break;
      end
      if (s_valid) nv++;
      tick();
    end
    chk("t2_done_seen", 32'(seen), 1);
    chk("t2_valid_cycles", 32'(nv), 16);
    chk("t2_step", 32'(s_step), 16);
    chk("t2_abc", s_abc, 15);
    ready_s = 1'b0;
    tick();
    chk("t2_idle", 32'(s_busy), 0);

    // Reset asserted in the middle of a hold-off gap.
    ready_d = 1'b1;
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (d_busy && !d_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t1_reached_hold", 32'(found), 1);
    tick();
    rst_n = 1'b0;
    ready_d = 1'b0;
    tick();
    chk("t1_busy", 32'(d_busy), 0);
    chk("t1_step", 32'(d_step), 0);
    chk("t1_abc", d_abc, 0);
    chk("t1_state", 32'(d_state), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full default sweep: random ready, 5-cycle stall at value 5,
    // start pulses while busy, and a look at the 383 -> 384 digit wrap.
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    seen = 0;
    bp_cnt = 0;
    wrap_pending = 0;
    for (int k = 0; k < 12000; k++) begin
      if (d_done) begin
        seen = 1;
        break;
      end
      if (d_valid && wrap_pending != 0) begin
        chk("t6_wrap", d_abc, 32'((3 << 7) | (0 << 1) | 0));
        wrap_pending = 0;
      end
      if (d_valid && d_abc == 5 && bp_cnt < 5) begin
        ready_d = 1'b0;
        bp_cnt++;
      end else begin
        ready_d = ($urandom_range(0, 3) != 0);
      end
      if (d_valid && ready_d && d_abc == 383) wrap_pending = 1;
      start_d = ($urandom_range(0, 15) == 0);
      tick();
    end
    start_d = 1'b0;
    ready_d = 1'b0;
    chk("t3_done_seen", 32'(seen), 1);
    chk("t4_stall_cycles", 32'(bp_cnt), 5);
    chk("t3_done_step", 32'(d_step), 1024);
    tick();
    chk("t3_idle", 32'(d_busy), 0);
    chk("t3_final_step", 32'(d_step), 1024);
    chk("t3_final_abc", d_abc, 32'(D_MAX));

    // Abort together with ready while step 7 is offered.
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    found = 0;
    for (int k = 0; k < 400; k++) begin
      if (d_valid && d_abc == 7) begin
        found = 1;
        break;
      end
      ready_d = $urandom_range(0, 1);
      start_d = ($urandom_range(0, 7) == 0);
      tick();
    end
    chk("t5_reached_7", 32'(found), 1);
    start_d = 1'b0;
    ready_d = 1'b1;
    abort_d = 1'b1;
    done_before = n_done[0];
    tick();
    abort_d = 1'b0;
    ready_d = 1'b0;
    chk("t5_busy", 32'(d_busy), 0);
    chk("t5_valid", 32'(d_valid), 0);
    chk("t5_step", 32'(d_step), 7);
    repeat (4) tick();
    chk("t5_no_done", 32'(n_done[0]), 32'(done_before));
    chk("t5_step_frozen", 32'(d_step), 7);

    // Abort during the hold-off gap.
    ready_d = 1'b1;
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (d_busy && !d_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t5b_reached_hold", 32'(found), 1);
    ready_d = 1'b0;
    abort_d = 1'b1;
    tick();
    abort_d = 1'b0;
    chk("t5b_busy", 32'(d_busy), 0);
    chk("t5b_step", 32'(d_step), 1);
    chk("t5b_abc", d_abc, 0);
    tick();

    // Random sweeps on the small instance: random ready, rare aborts,
    // start pulses while busy, and start+abort together in IDLE.
    for (int r = 0; r < 6; r++) begin
      start_s = 1'b1;
      abort_s = $urandom_range(0, 1);
      tick();
      start_s = 1'b0;
      abort_s = 1'b0;
      chk("s_start_wins", 32'(s_busy), 1);
      fin = 0;
      for (int k = 0; k < 300; k++) begin
        ready_s = $urandom_range(0, 1);
        abort_s = ($urandom_range(0, 39) == 0);
        start_s = ($urandom_range(0, 9) == 0);
        tick();
        if (!s_busy) begin
          fin = 1;
          break;
        end
      end
      start_s = 1'b0;
      abort_s = 1'b0;
      ready_s = 1'b0;
      chk("s_round_end", 32'(fin), 1);
      tick();
    end

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
